// File: rtl/regfile_read_port_if.sv
// Register-file bus: write port plus valid/ready read request and result
// channel. The master drives writes, requests and out_ready; the slave
// (register file) drives rd_ready and the registered result.
interface regfile_read_port_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             w_flag;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;

  logic             rd_req;
  logic             rd_ready;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;

  modport master (
    output w_flag, w_addr, w_data,
    output rd_req, rd_addr_a, rd_addr_b,
    input  rd_ready,
    input  out_valid, out_a, out_b,
    output out_ready
  );

  modport slave (
    input  w_flag, w_addr, w_data,
    input  rd_req, rd_addr_a, rd_addr_b,
    output rd_ready,
    output out_valid, out_a, out_b,
    input  out_ready
  );
endinterface

// File: rtl/regfile_read_port.sv
// Register file with one write port and a two-operand registered read port.
// Reads use a valid/ready handshake with 1-cycle latency; same-cycle write
// data is bypassed into a read of the same address, and the result is
// snapshotted so it holds stable under backpressure.
// Optional feature: define REGFILE_ZERO_REG_EN to hard-wire register 0 to 0
// (writes to address 0 dropped, reads of address 0 return 0, no bypass).

// One read operand: address mux, write bypass and the result snapshot.
module regfile_rd_lane #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int AW       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_i,
  input  logic [AW-1:0]                      addr_i,
  input  logic [NUM_REGS-1:0][WIDTH-1:0]     regs_i,
  input  logic                               w_flag_i,
  input  logic [AW-1:0]                      w_addr_i,
  input  logic [WIDTH-1:0]                   w_data_i,
  output logic [WIDTH-1:0]                   data_o
);
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] data_d, data_q;

  // Pick the operand value; a write landing this cycle wins over the array.
  always_comb begin
    rd_val = regs_i[addr_i];
    if (w_flag_i && (w_addr_i == addr_i)) rd_val = w_data_i;
`ifdef REGFILE_ZERO_REG_EN
    // Register 0 reads as zero even against a same-cycle write to it.
    if (addr_i == '0) rd_val = '0;
`endif
    data_d = load_i ? rd_val : data_q;
  end

  // Result snapshot: only an accepted request changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

module regfile_read_port #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int AW       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_read_port_if.slave  bus
);
  localparam int NOPS = 2;  // lane 0 = operand A, lane 1 = operand B

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                            state_q, state_d;
  logic [NUM_REGS-1:0][WIDTH-1:0]    regs_q, regs_d;
  logic                              rd_ready;
  logic                              accept;
  logic [NOPS-1:0][AW-1:0]           op_addr;
  logic [NOPS-1:0][WIDTH-1:0]        op_data;

  // The port can take a request when it is empty or its result drains now.
  assign rd_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept   = bus.rd_req && rd_ready;

  // Write port: never stalled by the read-side handshake.
  always_comb begin
    regs_d = regs_q;
    if (bus.w_flag) regs_d[bus.w_addr] = bus.w_data;
`ifdef REGFILE_ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  // Register array state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Read-side occupancy: EMPTY until accept, FULL until drained with no refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL: begin
        if (accept)             state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign op_addr = {bus.rd_addr_b, bus.rd_addr_a};

  // One lane per operand; both lanes load on the same accept.
  for (genvar g = 0; g < NOPS; g++) begin : g_lane
    regfile_rd_lane #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (accept),
      .addr_i   (op_addr[g]),
      .regs_i   (regs_q),
      .w_flag_i (bus.w_flag),
      .w_addr_i (bus.w_addr),
      .w_data_i (bus.w_data),
      .data_o   (op_data[g])
    );
  end

  assign bus.rd_ready  = rd_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_a     = op_data[0];
  assign bus.out_b     = op_data[1];
endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed steps from the test plan followed by
// random traffic, all compared against a plain array/handshake model.
module tb_regfile_read_port;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  regfile_read_port_if #(.WIDTH(16), .AW(4)) bus ();

  regfile_read_port #(.WIDTH(16), .NUM_REGS(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [15:0] m_regs [16];
  logic        m_valid;
  logic [15:0] m_a, m_b;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] a);
    if (ZERO_EN && a == 4'd0) return 16'h0000;
    if (bus.w_flag && bus.w_addr == a) return bus.w_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_valid = 1'b0;
    m_a = 16'h0;
    m_b = 16'h0;
  endtask

  task automatic drive(input logic wf, input logic [3:0] wa, input logic [15:0] wd,
                       input logic rq, input logic [3:0] aa, input logic [3:0] ab,
                       input logic ordy);
    bus.w_flag = wf; bus.w_addr = wa; bus.w_data = wd;
    bus.rd_req = rq; bus.rd_addr_a = aa; bus.rd_addr_b = ab;
    bus.out_ready = ordy;
  endtask

  // Called at posedge+1 with inputs set: check ready, advance model one edge,
  // then check the registered outputs.
  task automatic cycle();
    logic        rdy, nv;
    logic [15:0] na, nb;
    #1;
    rdy = !m_valid || bus.out_ready;
    chk("rd_ready", {31'b0, bus.rd_ready}, {31'b0, rdy});
    nv = m_valid; na = m_a; nb = m_b;
    if (bus.rd_req && rdy) begin
      nv = 1'b1;
      na = model_rd(bus.rd_addr_a);
      nb = model_rd(bus.rd_addr_b);
    end else if (m_valid && bus.out_ready) begin
      nv = 1'b0;
    end
    if (bus.w_flag && !(ZERO_EN && bus.w_addr == 4'd0)) m_regs[bus.w_addr] = bus.w_data;
    @(posedge clk);
    #1;
    m_valid = nv; m_a = na; m_b = nb;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    chk("out_a", {16'b0, bus.out_a}, {16'b0, m_a});
    chk("out_b", {16'b0, bus.out_b}, {16'b0, m_b});
  endtask

  // Watchdog: the bench is cycle-driven, this only catches a stuck simulator.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);

    // Reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_a", {16'b0, bus.out_a}, 32'd0);
    chk("rst_out_b", {16'b0, bus.out_b}, 32'd0);
    chk("rst_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
    rst_n = 1'b1;

    // Read after reset: A=3, B=7
    drive(0, 0, 0, 1, 4'd3, 4'd7, 1); cycle();
    chk("rr_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("rr_a", {16'b0, bus.out_a}, 32'h0000);

    // Write reg5 then read 5,5
    drive(1, 4'd5, 16'hBEEF, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 1, 4'd5, 4'd5, 1); cycle();
    chk("wr_a", {16'b0, bus.out_a}, 32'hBEEF);
    chk("wr_b", {16'b0, bus.out_b}, 32'hBEEF);

    // Bypass: reg2=0x00AA, then write 9 and read 9,2 same cycle
    drive(1, 4'd2, 16'h00AA, 0, 0, 0, 1); cycle();
    drive(1, 4'd9, 16'h1234, 1, 4'd9, 4'd2, 1); cycle();
    chk("byp_a", {16'b0, bus.out_a}, 32'h1234);
    chk("byp_b", {16'b0, bus.out_b}, 32'h00AA);

    // Both operands bypass at once
    drive(1, 4'd11, 16'h7E7E, 1, 4'd11, 4'd11, 1); cycle();
    chk("byp2_b", {16'b0, bus.out_b}, 32'h7E7E);

    // Backpressure hold
    drive(1, 4'd6, 16'h0011, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 1, 4'd6, 4'd6, 0); cycle();
    chk("bp_first", {16'b0, bus.out_a}, 32'h0011);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd6, 16'hFFFF, 1, 4'd6, 4'd6, 0);
      #1;
      chk("bp_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
      cycle();
      chk("bp_hold_a", {16'b0, bus.out_a}, 32'h0011);
      chk("bp_hold_v", {31'b0, bus.out_valid}, 32'd1);
    end
    drive(0, 0, 0, 1, 4'd6, 4'd6, 1); cycle();
    chk("bp_after", {16'b0, bus.out_a}, 32'hFFFF);

    // Back-to-back over preloaded 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'(i), {2{8'(i)}}, 0, 0, 0, 1); cycle();
    end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 4'(i), 4'(5 - i), 1); cycle();
      chk("b2b_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("b2b_a", {16'b0, bus.out_a}, 32'(i * 16'h0101));
    end

    // Register 0 behaviour
    drive(1, 4'd0, 16'h5555, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 1, 4'd0, 4'd0, 1); cycle();
    chk("zero_a", {16'b0, bus.out_a}, ZERO_EN ? 32'h0000 : 32'h5555);
    drive(1, 4'd0, 16'h6666, 1, 4'd0, 4'd1, 1); cycle();
    chk("zero_byp", {16'b0, bus.out_a}, ZERO_EN ? 32'h0000 : 32'h6666);

    // Async reset while holding
    drive(0, 0, 0, 1, 4'd5, 4'd2, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    chk("ar_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_a", {16'b0, bus.out_a}, 32'd0);
    chk("ar_b", {16'b0, bus.out_b}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 4'd5, 4'd2, 1); cycle();
    chk("ar_regs_clr", {16'b0, bus.out_a}, 32'h0000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
            1'($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 9) < 6));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
